// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared constants for the multicycle MIPS control path
//
// Purpose: opcode values, control FSM state encoding, OpALU codes shared with
// the ULA control block, and the ALUSrcB / PCSource select encodings.
// Ports: none (package).

package mips_ctrl_pkg;

  // Instruction opcodes, instr[31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Control FSM states; encodings 13..15 are unused and recover to S_ILLEGAL
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  // OpALU codes understood by the ULA control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - wrapping count of retired instructions
//
// Purpose: W-bit up counter with enable and asynchronous active-low clear.
// Ports:
//   clk   in  clock
//   rst_n in  async active-low clear
//   en    in  increment on this posedge
//   count out current count, wraps modulo 2^W

module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle MIPS datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback for R-type, lw, sw,
// beq, j and addi; drives datapath selects and write enables; stalls on
// mem_ready; flags illegal opcodes; counts retired instructions.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   opcode            instr[31:26] from the instruction register
//   mem_ready         memory finished the current access this cycle
//   PCWrite..RegWrite datapath write enables / 1-bit selects
//   ALUSrcA/B         ALU operand selects
//   PCSource          next-PC select
//   OpALU             operation class for the ULA control block
//   illegal           high while parked in the illegal-opcode state
//   instr_retired     one-cycle pulse on the completing cycle
//   retired_cnt       retired-instruction count (CNT_W bits, wraps)

module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       OpALU,
  output logic             illegal,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // opcode matters only in DECODE and MEM_ADDR; mem_ready only in the
  // three memory-access states.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:     if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_R:         state_next = S_EXEC_R;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_EXEC_I;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_next = S_MEM_READ;
        else if (opcode == OP_SW) state_next = S_MEM_WRITE;
        else                      state_next = S_ILLEGAL;
      end
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
      S_MEM_WB:    state_next = S_FETCH;
      S_EXEC_R:    state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
      S_EXEC_I:    state_next = S_I_WB;
      S_I_WB:      state_next = S_FETCH;
      S_ILLEGAL:   state_next = S_ILLEGAL;
      default:     state_next = S_ILLEGAL;
    endcase
  end

  // Outputs are gated by rst_n so nothing (not even the FETCH read request)
  // reaches the datapath while reset is held.
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    PCSource      = PCSRC_ALU;
    OpALU         = ALUOP_ADD;
    illegal       = 1'b0;
    instr_retired = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM_SH2;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite      = 1'b1;
          MemtoReg      = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite      = 1'b1;
          IorD          = 1'b1;
          instr_retired = mem_ready;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          OpALU   = ALUOP_FUNCT;
        end
        S_R_WB: begin
          RegWrite      = 1'b1;
          RegDst        = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA       = 1'b1;
          OpALU         = ALUOP_SUB;
          PCWriteCond   = 1'b1;
          PCSource      = PCSRC_ALUOUT;
          instr_retired = 1'b1;
        end
        S_JUMP: begin
          PCWrite       = 1'b1;
          PCSource      = PCSRC_JUMP;
          instr_retired = 1'b1;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_I_WB: begin
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        S_ILLEGAL: begin
          illegal = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  retire_counter #(
    .W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (instr_retired),
    .count (retired_cnt)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;

  localparam logic [5:0] R_OP    = 6'b000000;
  localparam logic [5:0] LW_OP   = 6'b100011;
  localparam logic [5:0] SW_OP   = 6'b101011;
  localparam logic [5:0] BEQ_OP  = 6'b000100;
  localparam logic [5:0] J_OP    = 6'b000010;
  localparam logic [5:0] ADDI_OP = 6'b001000;

  // Instruction phases as the datapath sees them
  localparam int PH_RST = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MADDR = 3,
                 PH_MREAD = 4, PH_MWB = 5, PH_MWRITE = 6, PH_EXR = 7,
                 PH_RWB = 8, PH_BR = 9, PH_JMP = 10, PH_EXI = 11,
                 PH_IWB = 12, PH_ILL = 13;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcsrc, op;
    logic       ill, ret;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal, instr_retired;
  logic [1:0] ALUSrcB, PCSource, OpALU;
  logic [31:0] retired_cnt;

  logic       s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead, s_MemWrite, s_IRWrite;
  logic       s_MemtoReg, s_RegDst, s_RegWrite, s_ALUSrcA, s_illegal, s_instr_retired;
  logic [1:0] s_ALUSrcB, s_PCSource, s_OpALU;
  logic [3:0] s_retired_cnt;

  int          errors = 0;
  int          checks = 0;
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .OpALU(OpALU), .illegal(illegal), .instr_retired(instr_retired),
    .retired_cnt(retired_cnt)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IorD(s_IorD),
    .MemRead(s_MemRead), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
    .MemtoReg(s_MemtoReg), .RegDst(s_RegDst), .RegWrite(s_RegWrite),
    .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .PCSource(s_PCSource),
    .OpALU(s_OpALU), .illegal(s_illegal), .instr_retired(s_instr_retired),
    .retired_cnt(s_retired_cnt)
  );

  // Required outputs of each phase, straight from the control table
  function automatic ov_t expv(int ph, logic rdy);
    ov_t e;
    e = '0;
    case (ph)
      PH_FETCH:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      PH_DECODE: begin e.srcb = 2'b11; end
      PH_MADDR:  begin e.srca = 1; e.srcb = 2'b10; end
      PH_MREAD:  begin e.mrd = 1; e.iord = 1; end
      PH_MWB:    begin e.rw = 1; e.m2r = 1; e.ret = 1; end
      PH_MWRITE: begin e.mwr = 1; e.iord = 1; e.ret = rdy; end
      PH_EXR:    begin e.srca = 1; e.op = 2'b10; end
      PH_RWB:    begin e.rw = 1; e.rdst = 1; e.ret = 1; end
      PH_BR:     begin e.srca = 1; e.op = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; e.ret = 1; end
      PH_JMP:    begin e.pcw = 1; e.pcsrc = 2'b10; e.ret = 1; end
      PH_EXI:    begin e.srca = 1; e.srcb = 2'b10; end
      PH_IWB:    begin e.rw = 1; e.ret = 1; end
      PH_ILL:    begin e.ill = 1; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  function automatic ov_t obs_main();
    ov_t o;
    o.pcw = PCWrite; o.pcwc = PCWriteCond; o.iord = IorD; o.mrd = MemRead;
    o.mwr = MemWrite; o.irw = IRWrite; o.m2r = MemtoReg; o.rdst = RegDst;
    o.rw = RegWrite; o.srca = ALUSrcA; o.srcb = ALUSrcB; o.pcsrc = PCSource;
    o.op = OpALU; o.ill = illegal; o.ret = instr_retired;
    return o;
  endfunction

  function automatic ov_t obs_small();
    ov_t o;
    o.pcw = s_PCWrite; o.pcwc = s_PCWriteCond; o.iord = s_IorD; o.mrd = s_MemRead;
    o.mwr = s_MemWrite; o.irw = s_IRWrite; o.m2r = s_MemtoReg; o.rdst = s_RegDst;
    o.rw = s_RegWrite; o.srca = s_ALUSrcA; o.srcb = s_ALUSrcB; o.pcsrc = s_PCSource;
    o.op = s_OpALU; o.ill = s_illegal; o.ret = s_instr_retired;
    return o;
  endfunction

  function automatic logic [5:0] junk_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic junk_rdy();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, check at negedge, advance past posedge
  task automatic step(int ph, logic rdy, logic [5:0] op, string tag);
    ov_t e, o, o4;
    logic [3:0] exp4;
    mem_ready = rdy;
    opcode    = op;
    @(negedge clk);
    e    = expv(ph, rdy);
    o    = obs_main();
    o4   = obs_small();
    exp4 = 4'(model_cnt % 16);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s outputs: got %h required %h", tag, o, e);
    end
    checks++;
    if (o4 !== e) begin
      errors++;
      $display("FAIL %s outputs(cnt4): got %h required %h", tag, o4, e);
    end
    checks++;
    if (retired_cnt !== model_cnt) begin
      errors++;
      $display("FAIL %s retired_cnt: got %0d required %0d", tag, retired_cnt, model_cnt);
    end
    checks++;
    if (s_retired_cnt !== exp4) begin
      errors++;
      $display("FAIL %s retired_cnt4: got %0d required %0d", tag, s_retired_cnt, exp4);
    end
    @(posedge clk);
    #1;
    if (e.ret) model_cnt++;
  endtask

  task automatic do_reset(int cycles);
    rst_n     = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < cycles; i++) step(PH_RST, junk_rdy(), junk_op(), "reset");
    rst_n = 1'b1;
  endtask

  task automatic run_instr(logic [5:0] op, int fs, int ms, string tag);
    for (int i = 0; i < fs; i++) step(PH_FETCH, 1'b0, junk_op(), tag);
    step(PH_FETCH, 1'b1, junk_op(), tag);
    step(PH_DECODE, junk_rdy(), op, tag);
    case (op)
      LW_OP: begin
        step(PH_MADDR, junk_rdy(), op, tag);
        for (int i = 0; i < ms; i++) step(PH_MREAD, 1'b0, junk_op(), tag);
        step(PH_MREAD, 1'b1, junk_op(), tag);
        step(PH_MWB, junk_rdy(), junk_op(), tag);
      end
      SW_OP: begin
        step(PH_MADDR, junk_rdy(), op, tag);
        for (int i = 0; i < ms; i++) step(PH_MWRITE, 1'b0, junk_op(), tag);
        step(PH_MWRITE, 1'b1, junk_op(), tag);
      end
      R_OP: begin
        step(PH_EXR, junk_rdy(), junk_op(), tag);
        step(PH_RWB, junk_rdy(), junk_op(), tag);
      end
      ADDI_OP: begin
        step(PH_EXI, junk_rdy(), junk_op(), tag);
        step(PH_IWB, junk_rdy(), junk_op(), tag);
      end
      BEQ_OP: step(PH_BR, junk_rdy(), junk_op(), tag);
      J_OP:   step(PH_JMP, junk_rdy(), junk_op(), tag);
      default: begin
        for (int i = 0; i < 20; i++) step(PH_ILL, junk_rdy(), junk_op(), tag);
      end
    endcase
  endtask

  task automatic test_reset();
    mem_ready = 1'b0;
    do_reset(3);
    step(PH_FETCH, 1'b0, junk_op(), "after_reset");
  endtask

  task automatic test_rtype();
    run_instr(R_OP, 0, 0, "rtype");
  endtask

  task automatic test_lw_stall();
    run_instr(LW_OP, 2, 3, "lw_stall");
  endtask

  task automatic test_beq_j();
    run_instr(BEQ_OP, 0, 0, "beq");
    run_instr(J_OP, 0, 0, "j");
  endtask

  task automatic test_illegal();
    logic [5:0] bad;
    run_instr(6'b111111, 0, 0, "illegal_3f");
    do_reset(1);
    run_instr(J_OP, 0, 0, "recover");
    do
      bad = junk_op();
    while (bad == R_OP || bad == LW_OP || bad == SW_OP || bad == BEQ_OP ||
           bad == J_OP || bad == ADDI_OP);
    run_instr(bad, 1, 0, "illegal_rand");
    do_reset(2);
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops = '{R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP};
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                $urandom_range(0, 2), "random");
  endtask

  task automatic test_wrap();
    do_reset(1);
    for (int i = 0; i < 16; i++) run_instr(J_OP, 0, 0, "wrap_j");
    step(PH_FETCH, 1'b0, junk_op(), "wrap_end");
  endtask

  task automatic test_reset_mid_write();
    step(PH_FETCH, 1'b1, junk_op(), "sw_abort");
    step(PH_DECODE, 1'b1, SW_OP, "sw_abort");
    step(PH_MADDR, 1'b1, SW_OP, "sw_abort");
    step(PH_MWRITE, 1'b0, junk_op(), "sw_abort");
    rst_n     = 1'b0;
    model_cnt = 0;
    step(PH_RST, 1'b1, junk_op(), "sw_abort_rst");
    step(PH_RST, 1'b1, junk_op(), "sw_abort_rst");
    rst_n = 1'b1;
    step(PH_FETCH, 1'b0, junk_op(), "sw_abort_release");
    run_instr(SW_OP, 0, 1, "sw_after_abort");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq_j();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, j and addi.
- Drives the datapath mux selects and write enables, and supplies OpALU to the ULA control block.
- Stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
clk  in  1  system clock; state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
opcode  in  6  instr[31:26], taken from the instruction register.
mem_ready  in  1  memory completed the current read/write this cycle.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load qualified by ALU zero (beq).
IorD  out  1  memory address select: 0=PC, 1=ALUOut.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
IRWrite  out  1  instruction register load.
MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR.
RegDst  out  1  write register: 0=rt, 1=rd.
RegWrite  out  1  register file write.
ALUSrcA  out  1  0=PC, 1=A.
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
OpALU  out  2  to ULA control: 00=add, 01=sub (beq), 10=funct-decoded.
illegal  out  1  sticky; high in ILLEGAL state.
instr_retired  out  1  one-cycle pulse when an instruction completes.
retired_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Moore FSM; 4-bit state register, posedge clk. All outputs decode from the state register (plus mem_ready where noted), so they are stable from posedge. The negedge-sampling ULA control therefore sees settled OpALU.
- Reset (rst_n=0, async): state=FETCH, retired_cnt=0, illegal=0. While rst_n=0, every output is forced to 0 (including MemRead and IRWrite).
- Outputs default to 0; only the listed signals assert in each state.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- States, outputs and transitions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, OpALU=00, PCSource=00; IRWrite=PCWrite=mem_ready. Holds while mem_ready=0. Goes to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, OpALU=00. Next state by opcode: lw/sw→MEM_ADDR, R→EXEC_R, beq→BRANCH, j→JUMP, addi→EXEC_I, any other→ILLEGAL.
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, OpALU=00. lw→MEM_READ, sw→MEM_WRITE.
  - MEM_READ(3): MemRead=1, IorD=1. Holds until mem_ready, then goes to MEM_WB.
  - MEM_WB(4): RegWrite=1, MemtoReg=1, RegDst=0; retire; →FETCH.
  - MEM_WRITE(5): MemWrite=1, IorD=1. Holds until mem_ready; on mem_ready retire and →FETCH.
  - EXEC_R(6): ALUSrcA=1, ALUSrcB=00, OpALU=10; →R_WB.
  - R_WB(7): RegWrite=1, RegDst=1, MemtoReg=0; retire; →FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01; retire; →FETCH.
  - JUMP(9): PCWrite=1, PCSource=10; retire; →FETCH.
  - EXEC_I(10): ALUSrcA=1, ALUSrcB=10, OpALU=00; →I_WB.
  - I_WB(11): RegWrite=1, RegDst=0, MemtoReg=0; retire; →FETCH.
  - ILLEGAL(12): illegal=1, all enables 0. Absorbing; exit only by reset.
  - Unused encodings (13–15): →ILLEGAL.
- Retire: instr_retired=1 for exactly the completing cycle, and retired_cnt increments on that posedge. retired_cnt wraps from all-ones to 0.
- opcode is sampled only in DECODE and MEM_ADDR, so changes in other states are ignored.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- Reset asserted mid-instruction aborts it: no retire, counter cleared, FETCH on release.
- Cycle counts with mem_ready always high: lw=5, sw=4, R=4, addi=4, beq=3, j=3.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants;
  - state encoding constants;
  - OpALU constants (the same ones the ULA control uses);
  - ALUSrcB and PCSource select constants.
- Natural sub-module: retire_counter (CNT_W-bit counter with enable, async active-low clear).

Test Plan:
1. Reset held 3 cycles, mid-reset outputs checked → all outputs 0; after release state=FETCH, MemRead=1, retired_cnt=0.
2. R-type add (opcode 000000), mem_ready=1 → OpALU=10 in EXEC_R; RegWrite=1, RegDst=1 in R_WB; instr_retired pulses on cycle 4; retired_cnt=1.
3. lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ → MemRead held, IRWrite/PCWrite=0 while stalled; retire on cycle 10; MemtoReg=1 at writeback.
4. beq (000100) → BRANCH asserts OpALU=01, PCWriteCond=1, PCSource=01; retires in 3 cycles. Then j (000010) → PCWrite=1, PCSource=10; retired_cnt=2.
5. opcode 111111 in DECODE → ILLEGAL; illegal=1 and all enables 0 for 20 cycles despite toggling mem_ready. rst_n pulse → recovers to FETCH.
6. CNT_W=4, 16 consecutive j instructions → retired_cnt wraps 15→0. Reset asserted during MEM_WRITE → no MemWrite after reset and no retire pulse.
